// File: rtl/cmp_sort_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_sort_ctrl_pkg
//  Description : Shared definitions for the sequential sort controller.
//                Holds the comparator result codes, the controller state
//                encoding and a saturating 8-bit increment helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package cmp_sort_ctrl_pkg;

    // One-hot magnitude-comparator result codes (A = elem[idx], B = elem[idx+1])
    localparam logic [2:0] CMP_GT = 3'b100;
    localparam logic [2:0] CMP_EQ = 3'b010;
    localparam logic [2:0] CMP_LT = 3'b001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Swap counter stops at 255 instead of wrapping
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cmp_sort_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_sort_ctrl_if
//  Description : Host-side bundle of the sort controller.
//                start/din    : request and unsorted vector (host -> sorter)
//                busy/done    : status, done is a one-cycle pulse
//                dout/swap_cnt: sorted vector and swap count of last sort
//                master = host/loader, slave = sorter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cmp_sort_ctrl_if #(
    parameter int W = 4,
    parameter int N = 4
);
    logic           start;
    logic [N*W-1:0] din;
    logic           busy;
    logic           done;
    logic [N*W-1:0] dout;
    logic [7:0]     swap_cnt;

    modport master (
        output start, din,
        input  busy, done, dout, swap_cnt
    );

    modport slave (
        input  start, din,
        output busy, done, dout, swap_cnt
    );
endinterface
`default_nettype wire

// File: rtl/cmp_sort_ctrl_mag_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : mag_cmp
//  Description : Purely combinational unsigned magnitude comparator with a
//                one-hot result: GT / EQ / LT.
//                Ports: a, b (W-bit unsigned operands), res (3-bit one-hot).
//  Revision    : 1.0 - initial release
// ============================================================================
module mag_cmp
    import cmp_sort_ctrl_pkg::*;
#(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [2:0]   res
);

    always_comb begin
        res = CMP_EQ;
        if (a > b) begin
            res = CMP_GT;
        end else if (a < b) begin
            res = CMP_LT;
        end
    end

endmodule
`default_nettype wire

// File: rtl/cmp_sort_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_sort_ctrl
//  Description : Sequential bubble-sort controller. Loads N unsigned W-bit
//                elements on start, sorts them ascending with one compare per
//                clock on a single shared comparator, exits early on a pass
//                without swaps, then publishes dout/swap_cnt with a done pulse.
//                Ports: clk, rst_n (synchronous, active-low),
//                       bus (slave modport: start, din, busy, done, dout,
//                       swap_cnt).
//  Revision    : 1.0 - initial release
// ============================================================================
module cmp_sort_ctrl
    import cmp_sort_ctrl_pkg::*;
#(
    parameter int W = 4,
    parameter int N = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    cmp_sort_ctrl_if.slave       bus
);

    localparam int            IW     = $clog2(N) + 1;
    localparam logic [IW-1:0] c_last = IW'(N - 2);

    state_t         r_state, w_state_nxt;
    logic [W-1:0]   r_elem      [N];
    logic [W-1:0]   w_elem_nxt  [N];
    logic [IW-1:0]  r_pass, w_pass_nxt;
    logic [IW-1:0]  r_idx, w_idx_nxt;
    logic           r_pass_swapped, w_pass_swapped_nxt;
    logic [7:0]     r_cnt, w_cnt_nxt;
    logic           r_busy, w_busy_nxt;
    logic           r_done, w_done_nxt;
    logic [N*W-1:0] r_dout, w_dout_nxt;
    logic [7:0]     r_swap_cnt, w_swap_cnt_nxt;

    logic [W-1:0]   w_a, w_b;
    logic [2:0]     w_cmp_res;
    logic           w_swap_now;

    // Select the adjacent pair at idx for the shared comparator
    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < N - 1; i++) begin
            if (r_idx == IW'(i)) begin
                w_a = r_elem[i];
                w_b = r_elem[i+1];
            end
        end
    end

    mag_cmp #(
        .W (W)
    ) u_mag_cmp (
        .a   (w_a),
        .b   (w_b),
        .res (w_cmp_res)
    );

    // Only strictly-greater swaps, so equal elements keep their order
    assign w_swap_now = (w_cmp_res == CMP_GT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_pass         <= '0;
            r_idx          <= '0;
            r_pass_swapped <= 1'b0;
            r_cnt          <= '0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_dout         <= '0;
            r_swap_cnt     <= '0;
            for (int i = 0; i < N; i++) begin
                r_elem[i] <= '0;
            end
        end else begin
            r_state        <= w_state_nxt;
            r_pass         <= w_pass_nxt;
            r_idx          <= w_idx_nxt;
            r_pass_swapped <= w_pass_swapped_nxt;
            r_cnt          <= w_cnt_nxt;
            r_busy         <= w_busy_nxt;
            r_done         <= w_done_nxt;
            r_dout         <= w_dout_nxt;
            r_swap_cnt     <= w_swap_cnt_nxt;
            r_elem         <= w_elem_nxt;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_elem_nxt         = r_elem;
        w_pass_nxt         = r_pass;
        w_idx_nxt          = r_idx;
        w_pass_swapped_nxt = r_pass_swapped;
        w_cnt_nxt          = r_cnt;
        w_busy_nxt         = r_busy;
        w_done_nxt         = r_done;
        w_dout_nxt         = r_dout;
        w_swap_cnt_nxt     = r_swap_cnt;

        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    for (int i = 0; i < N; i++) begin
                        w_elem_nxt[i] = bus.din[i*W +: W];
                    end
                    w_pass_nxt         = '0;
                    w_idx_nxt          = '0;
                    w_pass_swapped_nxt = 1'b0;
                    w_cnt_nxt          = '0;
                    w_busy_nxt         = 1'b1;
                    w_state_nxt        = CMP;
                end
            end

            CMP: begin
                if (w_swap_now) begin
                    for (int i = 0; i < N - 1; i++) begin
                        if (r_idx == IW'(i)) begin
                            w_elem_nxt[i]   = r_elem[i+1];
                            w_elem_nxt[i+1] = r_elem[i];
                        end
                    end
                    w_cnt_nxt          = sat_inc8(r_cnt);
                    w_pass_swapped_nxt = 1'b1;
                end

                // Pass p covers idx 0..N-2-p; the tail above it is already in place
                if (r_idx < (c_last - r_pass)) begin
                    w_idx_nxt = r_idx + IW'(1);
                end else if (!(r_pass_swapped || w_swap_now) || (r_pass == c_last)) begin
                    // Publish including this edge's swap, if any
                    for (int i = 0; i < N; i++) begin
                        w_dout_nxt[i*W +: W] = w_elem_nxt[i];
                    end
                    w_swap_cnt_nxt = w_cnt_nxt;
                    w_busy_nxt     = 1'b0;
                    w_done_nxt     = 1'b1;
                    w_state_nxt    = DONE;
                end else begin
                    w_pass_nxt         = r_pass + IW'(1);
                    w_idx_nxt          = '0;
                    w_pass_swapped_nxt = 1'b0;
                end
            end

            DONE: begin
                w_done_nxt  = 1'b0;
                w_state_nxt = IDLE;
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.dout     = r_dout;
    assign bus.swap_cnt = r_swap_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cmp_sort_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cmp_sort_ctrl
//  Description : Self-checking bench for cmp_sort_ctrl. A reference model
//                derives sorted output, swap count (inversions) and compare
//                count (from the pass count needed) directly from the input
//                vector; a negedge process compares every cycle, and directed
//                tests pin latency and results with literal values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cmp_sort_ctrl;

    localparam int W = 4;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    cmp_sort_ctrl_if #(.W(W), .N(N)) bus ();

    cmp_sort_ctrl #(.W(W), .N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N*W-1:0] pack4(input int e0, input int e1, input int e2, input int e3);
        return {W'(e3), W'(e2), W'(e1), W'(e0)};
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [N*W-1:0] model_sort(input logic [N*W-1:0] v);
        int q[$];
        logic [N*W-1:0] r;
        for (int i = 0; i < N; i++) q.push_back(int'(v[i*W +: W]));
        q.sort();
        r = '0;
        for (int i = 0; i < N; i++) r[i*W +: W] = W'(q[i]);
        return r;
    endfunction

    // Each bubble swap removes exactly one inversion
    function automatic int model_inv(input logic [N*W-1:0] v);
        int c = 0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < i; j++)
                if (v[j*W +: W] > v[i*W +: W]) c++;
        return c;
    endfunction

    // Swapping passes = max number of larger elements left of any element;
    // one more silent pass confirms order, capped at N-1 passes.
    function automatic int model_compares(input logic [N*W-1:0] v);
        int k = 0;
        int p;
        int c = 0;
        for (int i = 0; i < N; i++) begin
            int t = 0;
            for (int j = 0; j < i; j++)
                if (v[j*W +: W] > v[i*W +: W]) t++;
            if (t > k) k = t;
        end
        p = (k + 1 > N - 1) ? N - 1 : k + 1;
        for (int q = 0; q < p; q++) c += N - 1 - q;
        return c;
    endfunction

    bit             m_valid = 1'b0;
    int             m_mode  = 0;   // 0 idle, 1 sorting, 2 done cycle
    int             m_left  = 0;
    logic           m_busy  = 1'b0;
    logic           m_done  = 1'b0;
    logic [N*W-1:0] m_dout  = '0;
    logic [7:0]     m_swap  = '0;
    logic [N*W-1:0] m_pend_dout = '0;
    logic [7:0]     m_pend_swap = '0;

    always @(posedge clk) begin
        m_valid <= 1'b1;
        if (!rst_n) begin
            m_mode <= 0;
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_dout <= '0;
            m_swap <= '0;
        end else begin
            case (m_mode)
                0: if (bus.start) begin
                    m_pend_dout <= model_sort(bus.din);
                    m_pend_swap <= 8'(model_inv(bus.din));
                    m_left      <= model_compares(bus.din);
                    m_busy      <= 1'b1;
                    m_mode      <= 1;
                end
                1: begin
                    m_left <= m_left - 1;
                    if (m_left == 1) begin
                        m_busy <= 1'b0;
                        m_done <= 1'b1;
                        m_dout <= m_pend_dout;
                        m_swap <= m_pend_swap;
                        m_mode <= 2;
                    end
                end
                default: begin
                    m_done <= 1'b0;
                    m_mode <= 0;
                end
            endcase
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy", bus.busy, m_busy);
            chk("done", bus.done, m_done);
            chk("dout", bus.dout, m_dout);
            chk("swap_cnt", bus.swap_cnt, m_swap);
            chk("cmp_code_legal",
                (dut.w_cmp_res == 3'b100) || (dut.w_cmp_res == 3'b010) || (dut.w_cmp_res == 3'b001),
                1'b1);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic run_sort(input string name, input logic [N*W-1:0] v,
                            input int exp_lat, input logic [N*W-1:0] exp_dout,
                            input int exp_swap);
        int cyc = 0;
        int busy_cyc;
        bit done_seen = 1'b0;
        bus.din   = v;
        bus.start = 1'b1;
        @(posedge clk);            // E0
        #1;
        bus.start = 1'b0;
        bus.din   = '1;            // must not disturb the running sort
        busy_cyc  = bus.busy ? 1 : 0;
        while (!done_seen && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            if (bus.done) done_seen = 1'b1;
            else if (bus.busy) busy_cyc++;
        end
        chk({name, "_latency"}, 64'(cyc), 64'(exp_lat));
        chk({name, "_busy_cycles"}, 64'(busy_cyc), 64'(exp_lat));
        chk({name, "_dout"}, bus.dout, exp_dout);
        chk({name, "_swap_cnt"}, bus.swap_cnt, 64'(exp_swap));
        @(posedge clk);
        #1;
        chk({name, "_done_pulse_end"}, bus.done, 1'b0);
        chk({name, "_dout_hold"}, bus.dout, exp_dout);
    endtask

    initial begin
        int dones;
        int first_done;

        // Reset held with start asserted: nothing may start
        rst_n     = 1'b0;
        bus.start = 1'b1;
        bus.din   = pack4(4, 3, 2, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_dout", bus.dout, '0);
        chk("rst_swap_cnt", bus.swap_cnt, '0);
        bus.start = 1'b0;
        rst_n     = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_after_rst_busy", bus.busy, 1'b0);

        run_sort("reverse",  pack4(4, 3, 2, 1),  6, pack4(1, 2, 3, 4), 6);
        run_sort("sorted",   pack4(1, 2, 3, 4),  3, pack4(1, 2, 3, 4), 0);
        run_sort("extremes", pack4(15, 0, 7, 0), 6, pack4(0, 0, 7, 15), 4);
        run_sort("all_eq",   pack4(5, 5, 5, 5),  3, pack4(5, 5, 5, 5), 0);

        // start while busy must be ignored
        bus.din   = pack4(4, 3, 2, 1);
        bus.start = 1'b1;
        @(posedge clk);            // E0
        #1;
        bus.start  = 1'b0;
        dones      = 0;
        first_done = -1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) begin
                bus.start = 1'b1;
                bus.din   = pack4(9, 9, 9, 9);
            end else if (c == 2) begin
                bus.start = 1'b0;
            end
            if (bus.done) begin
                dones++;
                if (first_done < 0) first_done = c;
            end
            if (c == 6) begin
                chk("busy_start_dout", bus.dout, pack4(1, 2, 3, 4));
                chk("busy_start_swap", bus.swap_cnt, 8'd6);
            end
        end
        chk("busy_start_done_count", 64'(dones), 64'd1);
        chk("busy_start_latency", 64'(first_done), 64'd6);

        // Reset in the middle of a sort
        bus.din   = pack4(4, 3, 2, 1);
        bus.start = 1'b1;
        @(posedge clk);            // E0
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_done", bus.done, 1'b0);
        chk("midrst_dout", bus.dout, '0);
        chk("midrst_swap", bus.swap_cnt, '0);
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            chk("midrst_no_done", bus.done, 1'b0);
        end
        run_sort("after_rst", pack4(2, 1, 3, 0), 6, pack4(0, 1, 2, 3), 4);

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cmp_sort_ctrl.md
Name: cmp_sort_ctrl

Overview:
Sequential sort controller. Accepts N unsigned W-bit values, sorts them ascending with a bubble sort, and signals completion.
All comparisons are time-shared on one magnitude-comparator instance, at one compare per clock.
Sits between a loader/host issuing start and downstream logic that consumes the sorted vector.

Parameters:
W, 4, element width in bits (unsigned)
N, 4, number of elements; legal range 2..16

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  request; sampled only in IDLE
din  input  N*W  unsorted elements; element i = din[i*W +: W]
busy  output  1  high from the start-accept edge until the DONE-entry edge
done  output  1  one-cycle pulse; dout valid from this cycle on
dout  output  N*W  sorted elements, ascending; element 0 = smallest
swap_cnt  output  8  number of swaps performed in the last completed sort

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous, active-low, sampled on the rising edge of clk.
- Reset values: state=IDLE, busy=0, done=0, dout=0, swap_cnt=0, internal element regs=0.
- Reset mid-operation: abort on the next edge, same values as above. No done pulse is produced.
- Comparator encoding:
  - 3'b100: A>B
  - 3'b010: A==B
  - 3'b001: A<B
  - Any other code is illegal; the bench asserts it never occurs.
  - A = elem[idx], B = elem[idx+1].
- IDLE:
  - start=1 at edge E0: load elem[i]=din[i*W +: W], pass=0, idx=0, pass_swapped=0, cnt=0, busy=1, go to CMP.
  - start=0: stay in IDLE.
- CMP, one compare per edge:
  - Result GT: swap elem[idx] and elem[idx+1], cnt+=1, pass_swapped=1.
  - Result EQ or LT: no swap. Equal elements are never swapped.
  - If idx < N-2-pass: idx+=1.
  - Otherwise the pass ends:
    - If (pass_swapped==0 after this compare) or pass==N-2: go to DONE.
    - Else: pass+=1, idx=0, pass_swapped=0.
- DONE-entry edge: dout<=sorted elems (this edge's swap included), swap_cnt<=cnt, busy<=0, done<=1.
- DONE, one cycle: done<=0 on the next edge, return to IDLE. start is ignored in DONE.
- Latency:
  - The sort finishes with done visible C cycles after E0, where C = number of compares.
  - Worst case C = N(N-1)/2 (6 for N=4).
  - Best case C = N-1 (input already sorted).
  - Back-to-back: next start is accepted no earlier than one cycle after done.
- Output hold: dout and swap_cnt hold their values until the next DONE entry. They are not disturbed during a new sort.
- start while busy: ignored. No re-load, no effect on the running sort.
- din changes after E0: no effect on the running sort.
- Width rules: all compares unsigned. Counters sized $clog2(N)+1. cnt saturates at 255 (unreachable for N<=16).

Decomposition:
- Shared package: compare-result constants CMP_GT=3'b100, CMP_EQ=3'b010, CMP_LT=3'b001; FSM state encodings IDLE, CMP, DONE.
- Sub-module mag_cmp (parameter W): inputs a, b; output res[2:0], purely combinational, one-hot per the encoding above. Instantiated once in cmp_sort_ctrl and driven by the idx-muxed element pair.
- The FSM, element register file and counters stay in cmp_sort_ctrl.

Test Plan:
- Reset: hold rst_n=0 for 3 edges with start=1 -> busy=0, done=0, dout=0, swap_cnt=0; no sort starts.
- Reverse input {4,3,2,1} (elem0..3), start one cycle -> done pulses 6 cycles after E0; dout={1,2,3,4}; swap_cnt=6; busy high exactly 6 cycles.
- Sorted input {1,2,3,4} -> done 3 cycles after E0 (early exit); dout unchanged; swap_cnt=0.
- Extremes and duplicates {F,0,7,0} -> dout={0,0,7,F}; swap_cnt=4; done 6 cycles after E0. All-equal {5,5,5,5} -> swap_cnt=0, done after 3 cycles.
- Start while busy: start {4,3,2,1}, then pulse start with din={9,9,9,9} at cycle 2 -> ignored; result {1,2,3,4}; exactly one done pulse.
- Reset mid-sort: drop rst_n at cycle 3 of {4,3,2,1} -> next edge gives IDLE with all outputs 0 and no done; a fresh sort of {2,1,3,0} then yields {0,1,2,3}, swap_cnt=4.
